// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: WM8731 address, init register table, line-in gain table and sequencer states.
package codec_cfg_pkg;
  localparam int NUM_REGS = 11;
  localparam int LINE_L_IDX = 2;
  localparam logic [7:0] WM8731_I2C_ADDR = 8'h34;
  localparam logic [15:0] INIT_TBL [NUM_REGS] = '{
    16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
    16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201
  };
  localparam logic [8:0] GAIN_TBL [4] = '{9'h017, 9'h01B, 9'h01F, 9'h013};
  typedef enum logic [2:0] {PWR_WAIT, LOAD, ISSUE, WAIT, GAP, RUN, ERROR} state_t;
endpackage

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom: maps word index and pedal mode to the 16-bit {addr, data} codec word.
module codec_cfg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  idx_i,
  input  logic        gain_i,
  input  logic [1:0]  mode_i,
  output logic [15:0] word_o
);
  logic [15:0] ent;
  logic [8:0]  g;
  always_comb begin
    g = GAIN_TBL[mode_i];
    ent = (idx_i < 4'(NUM_REGS)) ? INIT_TBL[idx_i] : '0;
    // gain updates address reg 0 then reg 1; table line-in entries take the live gain
    word_o = gain_i ? {6'd0, idx_i[0], g} :
             (idx_i == 4'(LINE_L_IDX) || idx_i == 4'(LINE_L_IDX + 1)) ? {ent[15:9], g} : ent;
  end
endmodule

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: powers up the WM8731, writes its init table over I2C, then tracks pedal-mode gain changes.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int POWERUP_CYC = 50000,
  parameter int GAP_CYC     = 500,
  parameter int MAX_RETRY   = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [1:0]  mode,
  input  logic        cfg_restart,
  input  logic        i2c_ready,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        i2c_start,
  output logic [23:0] i2c_data,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error
);
  localparam int CW = $clog2((POWERUP_CYC > GAP_CYC ? POWERUP_CYC : GAP_CYC) + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] gmode_q, gmode_d;
  logic [23:0] data_q, data_d;
  logic gain_q, gain_d, start_q, start_d, done_q, done_d, err_q, err_d;
  logic cap;
  logic [3:0] last_idx;
  logic [15:0] rom_word;
  // the left line-in word samples the live mode; the right word reuses it so the pair matches
  assign cap = gain_q ? (idx_q == 4'd0) : (idx_q == 4'(LINE_L_IDX));
  assign last_idx = gain_q ? 4'd2 : 4'(NUM_REGS);
  codec_cfg_rom u_rom (
    .idx_i  (idx_q),
    .gain_i (gain_q),
    .mode_i (cap ? mode : gmode_q),
    .word_o (rom_word)
  );
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PWR_WAIT;
      cnt_q <= '0;
      retry_q <= '0;
      idx_q <= '0;
      gmode_q <= '0;
      data_q <= '0;
      gain_q <= 1'b0;
      start_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      retry_q <= retry_d;
      idx_q <= idx_d;
      gmode_q <= gmode_d;
      data_q <= data_d;
      gain_q <= gain_d;
      start_q <= start_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    retry_d = retry_q;
    idx_d = idx_q;
    gmode_d = gmode_q;
    data_d = data_q;
    gain_d = gain_q;
    start_d = 1'b0;
    done_d = done_q;
    err_d = err_q;
    unique case (state_q)
      PWR_WAIT: begin
        cnt_d = (cnt_q == CW'(POWERUP_CYC - 1)) ? '0 : cnt_q + CW'(1);
        state_d = (cnt_q == CW'(POWERUP_CYC - 1)) ? LOAD : PWR_WAIT;
      end
      LOAD: begin
        data_d = {WM8731_I2C_ADDR, rom_word};
        gmode_d = cap ? mode : gmode_q;
        state_d = ISSUE;
      end
      ISSUE: begin
        start_d = i2c_ready;
        state_d = i2c_ready ? WAIT : ISSUE;
      end
      WAIT: if (i2c_done) begin
        if (!i2c_nack) begin
          idx_d = idx_q + 4'd1;
          retry_d = '0;
          state_d = GAP;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          state_d = GAP;
        end else begin
          err_d = 1'b1;
          state_d = ERROR;
        end
      end
      GAP: if (cnt_q == CW'(GAP_CYC - 1)) begin
        cnt_d = '0;
        state_d = (idx_q == last_idx) ? RUN : LOAD;
        done_d = done_q | (idx_q == last_idx);
      end else cnt_d = cnt_q + CW'(1);
      RUN, ERROR: if (cfg_restart) begin
        state_d = LOAD;
        idx_d = '0;
        retry_d = '0;
        gain_d = 1'b0;
        done_d = 1'b0;
        err_d = 1'b0;
      end else if (state_q == RUN && mode != gmode_q) begin
        state_d = LOAD;
        idx_d = '0;
        retry_d = '0;
        gain_d = 1'b1;
      end
      default: state_d = PWR_WAIT;
    endcase
  end
  always_comb begin
    busy = !(state_q == RUN || state_q == ERROR);
    i2c_start = start_q;
    i2c_data = data_q;
    cfg_done = done_q;
    cfg_error = err_q;
  end
endmodule
